// File: rtl/block_cu_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : block_cu_gen_pkg
// Description : Shared state encoding and width helper for the block CU.
// Revision    : 1.0
// ============================================================================
package block_cu_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_RD  = 3'd1,
        S_LOAD_A  = 3'd2,
        S_LOAD_B  = 3'd3,
        S_WAIT_PU = 3'd4,
        S_REQ_WR  = 3'd5,
        S_WRITE   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    function automatic int clog2(input int value);
        int v;
        int r;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_cu_gen_addr.sv
`default_nettype none
// ============================================================================
// Module      : block_addr_gen
// Description : Combinational word address: base + row*N + col (mod 2^W).
// Revision    : 1.0
// ============================================================================
module block_addr_gen
    import block_cu_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic [ADDR_WIDTH-1:0] i_Base,
    input  logic [ADDR_WIDTH-1:0] i_Row,
    input  logic [ADDR_WIDTH-1:0] i_Col,
    input  logic [ADDR_WIDTH-1:0] i_N,
    output logic [ADDR_WIDTH-1:0] o_Address
);

    assign o_Address = i_Base + (i_Row * i_N) + i_Col;

endmodule
`default_nettype wire

// File: rtl/block_cu_gen.sv
`default_nettype none
// ============================================================================
// Module      : block_cu_gen
// Description : Block matrix-multiply control unit: loads A/B blocks into the
//               RF per step x, starts the PU, then writes the C block back.
// Revision    : 1.0
// ============================================================================
module block_cu_gen
    import block_cu_gen_pkg::*;
#(
    parameter int K           = 2,
    parameter int INDEX_WIDTH = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int MU_WIDTH    = 8,
    parameter int CNT_WIDTH   = (clog2(K*K) < 1) ? 1 : clog2(K*K)
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Indexes_Ready,
    input  logic [INDEX_WIDTH-1:0] i_Row_Index,
    input  logic [INDEX_WIDTH-1:0] i_Column_Index,
    input  logic [MU_WIDTH-1:0]    i_mu,
    input  logic [ADDR_WIDTH-1:0]  i_A_Base,
    input  logic [ADDR_WIDTH-1:0]  i_B_Base,
    input  logic [ADDR_WIDTH-1:0]  i_C_Base,
    output logic                   o_Indexes_Received,
    output logic                   o_Result_Ready,
    output logic                   o_Grant_Request,
    input  logic                   i_Grant,
    output logic                   o_Memory_Read_Enable,
    output logic                   o_Memory_Write_Enable,
    output logic [ADDR_WIDTH-1:0]  o_Memory_Address,
    output logic                   o_RF_Write_Enable,
    output logic                   o_RF_Read_Enable,
    output logic                   o_AorB,
    output logic [CNT_WIDTH-1:0]   o_RF_Address,
    output logic                   o_PU_Start,
    input  logic                   i_Partial_Output_Ready,
    output logic                   o_Busy
);

    localparam logic [CNT_WIDTH-1:0]  c_LAST_SUB = CNT_WIDTH'(K - 1);
    localparam logic [ADDR_WIDTH-1:0] c_K_A      = ADDR_WIDTH'(K);

    state_t                  r_state;
    state_t                  w_next;
    logic [INDEX_WIDTH-1:0]  r_i;
    logic [INDEX_WIDTH-1:0]  r_j;
    logic [MU_WIDTH-1:0]     r_mu;
    logic [MU_WIDTH-1:0]     r_x;
    logic [ADDR_WIDTH-1:0]   r_a_base;
    logic [ADDR_WIDTH-1:0]   r_b_base;
    logic [ADDR_WIDTH-1:0]   r_c_base;
    logic [CNT_WIDTH-1:0]    r_row;
    logic [CNT_WIDTH-1:0]    r_col;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_ack;
    logic                    r_pu_start;

    logic                    w_last_word;
    logic                    w_x_last;
    logic                    w_xfer;
    logic [ADDR_WIDTH-1:0]   w_n;
    logic [ADDR_WIDTH-1:0]   w_i_row;
    logic [ADDR_WIDTH-1:0]   w_x_row;
    logic [ADDR_WIDTH-1:0]   w_x_col;
    logic [ADDR_WIDTH-1:0]   w_j_col;
    logic [ADDR_WIDTH-1:0]   w_base;
    logic [ADDR_WIDTH-1:0]   w_row;
    logic [ADDR_WIDTH-1:0]   w_col;
    logic [ADDR_WIDTH-1:0]   w_addr;

    assign w_last_word = (r_row == c_LAST_SUB) && (r_col == c_LAST_SUB);
    assign w_x_last    = (r_x == (r_mu - MU_WIDTH'(1)));
    assign w_xfer      = i_Grant && ((r_state == S_LOAD_A) || (r_state == S_LOAD_B) ||
                                     (r_state == S_WRITE));

    // Global row/column of the current element within the full N x N matrix.
    assign w_n     = ADDR_WIDTH'(r_mu) * c_K_A;
    assign w_i_row = ADDR_WIDTH'(r_i) * c_K_A + ADDR_WIDTH'(r_row);
    assign w_x_row = ADDR_WIDTH'(r_x) * c_K_A + ADDR_WIDTH'(r_row);
    assign w_x_col = ADDR_WIDTH'(r_x) * c_K_A + ADDR_WIDTH'(r_col);
    assign w_j_col = ADDR_WIDTH'(r_j) * c_K_A + ADDR_WIDTH'(r_col);

    always_comb begin
        w_base = '0;
        w_row  = '0;
        w_col  = '0;
        case (r_state)
            S_LOAD_A: begin w_base = r_a_base; w_row = w_i_row; w_col = w_x_col; end
            S_LOAD_B: begin w_base = r_b_base; w_row = w_x_row; w_col = w_j_col; end
            S_WRITE:  begin w_base = r_c_base; w_row = w_i_row; w_col = w_j_col; end
            default:  ;
        endcase
    end

    block_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .i_Base    (w_base),
        .i_Row     (w_row),
        .i_Col     (w_col),
        .i_N       (w_n),
        .o_Address (w_addr)
    );

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next                = r_state;
        o_Grant_Request       = 1'b0;
        o_Memory_Read_Enable  = 1'b0;
        o_Memory_Write_Enable = 1'b0;
        o_RF_Write_Enable     = 1'b0;
        o_RF_Read_Enable      = 1'b0;
        o_AorB                = 1'b0;
        o_Result_Ready        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Indexes_Ready) w_next = S_REQ_RD;
            end
            S_REQ_RD: begin
                o_Grant_Request = 1'b1;
                if (i_Grant) w_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                o_Grant_Request      = 1'b1;
                o_Memory_Read_Enable = i_Grant;
                o_RF_Write_Enable    = i_Grant;
                if (i_Grant && w_last_word) w_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                o_Grant_Request      = 1'b1;
                o_Memory_Read_Enable = i_Grant;
                o_RF_Write_Enable    = i_Grant;
                o_AorB               = 1'b1;
                if (i_Grant && w_last_word) w_next = S_WAIT_PU;
            end
            S_WAIT_PU: begin
                if (i_Partial_Output_Ready) w_next = w_x_last ? S_REQ_WR : S_REQ_RD;
            end
            S_REQ_WR: begin
                o_Grant_Request = 1'b1;
                if (i_Grant) w_next = S_WRITE;
            end
            S_WRITE: begin
                o_Grant_Request       = 1'b1;
                o_Memory_Write_Enable = i_Grant;
                o_RF_Read_Enable      = i_Grant;
                if (i_Grant && w_last_word) w_next = S_DONE;
            end
            S_DONE: begin
                o_Result_Ready = 1'b1;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_i        <= '0;
            r_j        <= '0;
            r_mu       <= '0;
            r_x        <= '0;
            r_a_base   <= '0;
            r_b_base   <= '0;
            r_c_base   <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_cnt      <= '0;
            r_ack      <= 1'b0;
            r_pu_start <= 1'b0;
        end else begin
            r_ack      <= 1'b0;
            r_pu_start <= 1'b0;
            if ((r_state == S_IDLE) && i_Indexes_Ready) begin
                r_i      <= i_Row_Index;
                r_j      <= i_Column_Index;
                r_mu     <= (i_mu == '0) ? MU_WIDTH'(1) : i_mu;
                r_a_base <= i_A_Base;
                r_b_base <= i_B_Base;
                r_c_base <= i_C_Base;
                r_x      <= '0;
                r_row    <= '0;
                r_col    <= '0;
                r_cnt    <= '0;
                r_ack    <= 1'b1;
            end
            // Counters only move on granted transfers, so a grant drop resumes cleanly.
            if (w_xfer) begin
                if (w_last_word) begin
                    r_row <= '0;
                    r_col <= '0;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                    if (r_col == c_LAST_SUB) begin
                        r_col <= '0;
                        r_row <= r_row + CNT_WIDTH'(1);
                    end else begin
                        r_col <= r_col + CNT_WIDTH'(1);
                    end
                end
            end
            if ((r_state == S_LOAD_B) && i_Grant && w_last_word) r_pu_start <= 1'b1;
            if ((r_state == S_WAIT_PU) && i_Partial_Output_Ready && !w_x_last) begin
                r_x <= r_x + MU_WIDTH'(1);
            end
        end
    end

    assign o_Memory_Address   = w_addr;
    assign o_RF_Address       = r_cnt;
    assign o_Indexes_Received = r_ack;
    assign o_PU_Start         = r_pu_start;
    assign o_Busy             = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_block_cu_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_cu_gen
// Description : Bench for block_cu_gen; K=2 and K=3 instances share stimulus.
// Revision    : 1.0
// ============================================================================
module tb_block_cu_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ri, rj, rmu;
    logic [9:0] ra, rb, rc;
    logic       gnt;
    logic       rdy0, rdy1, pd0, pd1;

    logic       ack0, res0, greq0, mre0, mwe0, rfwe0, rfre0, aorb0, pus0, busy0;
    logic       ack1, res1, greq1, mre1, mwe1, rfwe1, rfre1, aorb1, pus1, busy1;
    logic [9:0] maddr0, maddr1;
    logic [1:0] rfa0;
    logic [3:0] rfa1;
    logic [31:0] outs0, outs1;

    int n_checks = 0;
    int n_errors = 0;
    int exp_rd [2][$];
    int obs_rd [2][$];
    int exp_wr [2][$];
    int obs_wr [2][$];

    always #5 clk = ~clk;

    assign outs0 = {9'd0, ack0, res0, greq0, mre0, mwe0, maddr0, rfwe0, rfre0, aorb0, rfa0, pus0, busy0};
    assign outs1 = {7'd0, ack1, res1, greq1, mre1, mwe1, maddr1, rfwe1, rfre1, aorb1, rfa1, pus1, busy1};

    block_cu_gen #(.K(2)) u_dut0 (
        .i_Clock(clk), .i_Reset(rst_n), .i_Indexes_Ready(rdy0),
        .i_Row_Index(ri), .i_Column_Index(rj), .i_mu(rmu),
        .i_A_Base(ra), .i_B_Base(rb), .i_C_Base(rc),
        .o_Indexes_Received(ack0), .o_Result_Ready(res0), .o_Grant_Request(greq0),
        .i_Grant(gnt), .o_Memory_Read_Enable(mre0), .o_Memory_Write_Enable(mwe0),
        .o_Memory_Address(maddr0), .o_RF_Write_Enable(rfwe0), .o_RF_Read_Enable(rfre0),
        .o_AorB(aorb0), .o_RF_Address(rfa0), .o_PU_Start(pus0),
        .i_Partial_Output_Ready(pd0), .o_Busy(busy0)
    );

    block_cu_gen #(.K(3)) u_dut1 (
        .i_Clock(clk), .i_Reset(rst_n), .i_Indexes_Ready(rdy1),
        .i_Row_Index(ri), .i_Column_Index(rj), .i_mu(rmu),
        .i_A_Base(ra), .i_B_Base(rb), .i_C_Base(rc),
        .o_Indexes_Received(ack1), .o_Result_Ready(res1), .o_Grant_Request(greq1),
        .i_Grant(gnt), .o_Memory_Read_Enable(mre1), .o_Memory_Write_Enable(mwe1),
        .o_Memory_Address(maddr1), .o_RF_Write_Enable(rfwe1), .o_RF_Read_Enable(rfre1),
        .o_AorB(aorb1), .o_RF_Address(rfa1), .o_PU_Start(pus1),
        .i_Partial_Output_Ready(pd1), .o_Busy(busy1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int enc(input int sel, input int rf, input int addr);
        return (sel << 20) | (rf << 12) | (addr & 1023);
    endfunction

    // Reference transfer lists straight from the address equations.
    task automatic build_expect(input int d, input int k, input int i, input int j,
                                input int mu, input int a, input int b, input int c);
        int me;
        int n;
        me = (mu == 0) ? 1 : mu;
        n  = me * k;
        exp_rd[d].delete();
        exp_wr[d].delete();
        for (int x = 0; x < me; x++) begin
            for (int w = 0; w < k*k; w++)
                exp_rd[d].push_back(enc(0, w, a + (i*k + w/k)*n + x*k + w%k));
            for (int w = 0; w < k*k; w++)
                exp_rd[d].push_back(enc(1, w, b + (x*k + w/k)*n + j*k + w%k));
        end
        for (int w = 0; w < k*k; w++)
            exp_wr[d].push_back(enc(0, w, c + (i*k + w/k)*n + j*k + w%k));
    endtask

    task automatic compare_lists(input int d);
        check_val($sformatf("rd_count%0d", d), obs_rd[d].size(), exp_rd[d].size());
        check_val($sformatf("wr_count%0d", d), obs_wr[d].size(), exp_wr[d].size());
        for (int n = 0; n < exp_rd[d].size() && n < obs_rd[d].size(); n++)
            check_val($sformatf("rd%0d[%0d]", d, n), obs_rd[d][n], exp_rd[d][n]);
        for (int n = 0; n < exp_wr[d].size() && n < obs_wr[d].size(); n++)
            check_val($sformatf("wr%0d[%0d]", d, n), obs_wr[d][n], exp_wr[d][n]);
    endtask

    // gmode: 0 grant high, 1 random grant, 2 grant dropped 3 cycles after 2nd A word.
    task automatic run_job(input int i, input int j, input int mu, input int a, input int b,
                           input int c, input int gmode, input bit hold, input bit rst_in_b);
        int  acks [2];
        int  pus  [2];
        int  ress [2];
        bit  done [2];
        bit  arm  [2];
        int  wait_pu [2];
        int  drop_left;
        bit  dropped;
        int  me;
        me = (mu == 0) ? 1 : mu;
        for (int d = 0; d < 2; d++) begin
            acks[d] = 0; pus[d] = 0; ress[d] = 0; done[d] = 0; arm[d] = 0; wait_pu[d] = 0;
            obs_rd[d].delete();
            obs_wr[d].delete();
        end
        drop_left = 0;
        dropped   = 0;
        build_expect(0, 2, i, j, mu, a, b, c);
        build_expect(1, 3, i, j, mu, a, b, c);
        @(negedge clk);
        ri = 8'(i); rj = 8'(j); rmu = 8'(mu);
        ra = 10'(a); rb = 10'(b); rc = 10'(c);
        rdy0 = 1'b1; rdy1 = 1'b1;
        gnt  = (gmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        for (int cyc = 0; cyc < 4000 && !(done[0] && done[1]); cyc++) begin
            @(negedge clk);
            if (ack0) acks[0]++;
            if (ack1) acks[1]++;
            if (pus0) begin pus[0]++; arm[0] = 1; wait_pu[0] = $urandom_range(0, 3); end
            if (pus1) begin pus[1]++; arm[1] = 1; wait_pu[1] = $urandom_range(0, 3); end
            if (res0) begin ress[0]++; done[0] = 1; end
            if (res1) begin ress[1]++; done[1] = 1; end
            if (mre0) obs_rd[0].push_back(enc(int'(aorb0), int'(rfa0), int'(maddr0)));
            if (mre1) obs_rd[1].push_back(enc(int'(aorb1), int'(rfa1), int'(maddr1)));
            if (mwe0) obs_wr[0].push_back(enc(0, int'(rfa0), int'(maddr0)));
            if (mwe1) obs_wr[1].push_back(enc(0, int'(rfa1), int'(maddr1)));
            if (!gnt) begin
                check_val("nogrant_strobes0", {mre0, mwe0, rfwe0, rfre0}, 0);
                check_val("nogrant_strobes1", {mre1, mwe1, rfwe1, rfre1}, 0);
            end
            if (rst_in_b && obs_rd[0].size() == 5) begin
                rst_n = 1'b0;
                #1;
                check_val("async_rst_outs0", outs0, 0);
                check_val("async_rst_outs1", outs1, 0);
                pd0 = 1'b0; pd1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            pd0 = 1'b0;
            pd1 = 1'b0;
            if (arm[0]) begin
                if (wait_pu[0] == 0) begin pd0 = 1'b1; arm[0] = 0; end
                else wait_pu[0]--;
            end
            if (arm[1]) begin
                if (wait_pu[1] == 0) begin pd1 = 1'b1; arm[1] = 0; end
                else wait_pu[1]--;
            end
            rdy0 = hold ? !done[0] : (acks[0] == 0);
            rdy1 = hold ? !done[1] : (acks[1] == 0);
            if (gmode == 0) begin
                gnt = 1'b1;
            end else if (gmode == 1) begin
                gnt = ($urandom_range(0, 3) != 0);
            end else begin
                if (!dropped && obs_rd[0].size() == 2) begin
                    dropped   = 1;
                    drop_left = 3;
                end
                if (drop_left > 0) begin gnt = 1'b0; drop_left--; end
                else gnt = 1'b1;
            end
        end
        if (!(done[0] && done[1])) check_val("job_timeout", 0, 1);
        rdy0 = 1'b0; rdy1 = 1'b0; pd0 = 1'b0; pd1 = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("ack_count%0d", d), acks[d], 1);
            check_val($sformatf("pu_start_count%0d", d), pus[d], me);
            check_val($sformatf("result_count%0d", d), ress[d], 1);
            compare_lists(d);
        end
        @(negedge clk);
        @(negedge clk);
        check_val("idle_busy", {busy0, busy1}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        ri = '0; rj = '0; rmu = '0; ra = '0; rb = '0; rc = '0;
        gnt = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0; pd0 = 1'b0; pd1 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outs0", outs0, 0);
        check_val("reset_outs1", outs1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(0, 0, 1, 0, 16, 32, 0, 0, 0);
        run_job(1, 0, 2, 0, 16, 32, 0, 0, 0);
        run_job(0, 0, 1, 0, 16, 32, 2, 0, 0);
        run_job(0, 1, 2, 100, 200, 300, 1, 0, 1);
        run_job(0, 0, 1, 0, 16, 32, 0, 0, 0);
        run_job(1, 1, 0, 5, 6, 7, 0, 0, 0);
        run_job(1, 0, 2, 0, 16, 32, 1, 1, 0);
        for (int t = 0; t < 8; t++) begin
            run_job($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3),
                    $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                    1, 1'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_cu_gen.md
BLOCK_CU_GEN -- requirements
Module: block_cu_gen

Interface
REQ-001 Parameter K, default 2: block edge, so one block is K*K words; K SHALL be at least 1.
REQ-002 Parameter INDEX_WIDTH, default 8: block row/column index width.
REQ-003 Parameter ADDR_WIDTH, default 10: memory address width.
REQ-004 Parameter MU_WIDTH, default 8: width of mu, the number of blocks per matrix edge.
REQ-005 Parameter CNT_WIDTH, default clog2(K*K), minimum 1: RF word address width.
REQ-006 Clock and reset: one clock, i_Clock; reset is asynchronous and active-low, i_Reset.
REQ-007 Ports (name, direction, width, meaning):
- i_Clock  in  1  clock
- i_Reset  in  1  async active-low reset
- i_Indexes_Ready  in  1  job valid
- i_Row_Index  in  INDEX_WIDTH  block row i
- i_Column_Index  in  INDEX_WIDTH  block column j
- i_mu  in  MU_WIDTH  blocks per edge; 0 is treated as 1
- i_A_Base, i_B_Base, i_C_Base  in  ADDR_WIDTH  matrix base addresses
- o_Indexes_Received  out  1  one-cycle job acknowledge
- o_Result_Ready  out  1  one-cycle done pulse
- o_Grant_Request  out  1  memory arbiter request
- i_Grant  in  1  arbiter grant
- o_Memory_Read_Enable, o_Memory_Write_Enable  out  1  memory strobes
- o_Memory_Address  out  ADDR_WIDTH  memory word address
- o_RF_Write_Enable, o_RF_Read_Enable  out  1  RF strobes
- o_AorB  out  1  0 selects A, 1 selects B
- o_RF_Address  out  CNT_WIDTH  RF word index
- o_PU_Start  out  1  one-cycle PU start
- i_Partial_Output_Ready  in  1  PU done pulse
- o_Busy  out  1  high whenever the state is not IDLE

Function
REQ-008 States SHALL be IDLE, REQ_RD, LOAD_A, LOAD_B, WAIT_PU, REQ_WR, WRITE, DONE.
REQ-009 IDLE with i_Indexes_Ready: latch i, j, mu and the three bases; pulse o_Indexes_Received for 1 cycle; set x=0; go to REQ_RD.
REQ-010 REQ_RD: assert o_Grant_Request; on i_Grant go to LOAD_A with the word counter at 0.
REQ-011 LOAD_A and LOAD_B each transfer exactly K*K words, one per granted cycle.
- Strobes: o_Memory_Read_Enable=1 and o_RF_Write_Enable=1.
- o_RF_Address = counter.
- o_AorB = 0 in LOAD_A, 1 in LOAD_B.
REQ-012 Element order SHALL be row-major: sub-row r = counter div K, sub-column c = counter mod K, held as separate r/c counters (no divider).
REQ-013 With N = mu*K, addresses SHALL be (all arithmetic modulo 2^ADDR_WIDTH):
- A: i_A_Base + (i*K+r)*N + x*K + c
- B: i_B_Base + (x*K+r)*N + j*K + c
- C: i_C_Base + (i*K+r)*N + j*K + c
REQ-014 If i_Grant drops during LOAD_A, LOAD_B or WRITE, strobes SHALL deassert, the counters SHALL hold, and the transfer SHALL resume at the same word when i_Grant returns.
REQ-015 On the last B word: drop o_Grant_Request, pulse o_PU_Start for 1 cycle, go to WAIT_PU.
REQ-016 WAIT_PU on i_Partial_Output_Ready:
- if x < mu-1: x <= x+1 and go to REQ_RD;
- otherwise go to REQ_WR.
REQ-017 REQ_WR/WRITE: request the grant, then write K*K words.
- Strobes: o_RF_Read_Enable=1 and o_Memory_Write_Enable=1.
- Address per REQ-013 (C).
- After the last word, release the grant and go to DONE.
REQ-018 DONE: pulse o_Result_Ready for 1 cycle and return to IDLE; i_Indexes_Ready outside IDLE SHALL be ignored.
REQ-019 Latency with grant always high, per x: 1 + 2*K*K + PU cycles; the final write adds 1 + K*K + 1 cycles.

Reset
REQ-020 Asserted reset SHALL immediately force IDLE, zero all counters and latched registers, and drive every output to 0, including mid-transfer; a partial job SHALL be discarded.

Structure
REQ-021 A shared package SHALL hold the state encoding and the clog2 function.
REQ-022 Address generation SHALL be one sub-module, block_addr_gen: combinational base + row*N + col.

Verification
REQ-023 K=2, mu=1, i=0, j=0, bases 0/16/32, grant always high:
- reads 0,1,2,3 then 16,17,18,19;
- writes 32,33,34,35;
- exactly one o_PU_Start and one o_Result_Ready.
REQ-024 K=2, mu=2, i=1, j=0, bases 0/16/32:
- x=0: A 8,9,12,13; B 16,17,20,21;
- x=1: A 10,11,14,15; B 24,25,28,29;
- C writes 40,41,44,45.
REQ-025 K=2, mu=1: drop i_Grant for 3 cycles after the second A word -> strobes low for 3 cycles, RF address resumes at 2, no word duplicated or skipped.
REQ-026 Reset asserted during LOAD_B -> all outputs 0 the same cycle; a new job after release starts at the A base.
REQ-027 mu=0 with K=3 -> behaves as mu=1 with 9 reads each for A and B and 9 writes.
REQ-028 i_Indexes_Ready held high throughout a job -> exactly one acknowledge per job; the next job starts only after DONE.
